// File: rtl/l1_buffer_addr_ctrl.sv
// Global L1 event-buffer address controller: turns accepted L1A triggers into
// write strobes/addresses and sequences preLoad -> load -> busy for readout.
module l1_buffer_addr_ctrl #(
  parameter int ADDRWIDTH    = 7,
  parameter int DROPCNTWIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    l1a,
  input  logic                    rdReq,
  input  logic                    rdDone,
  output logic                    wren,
  output logic [ADDRWIDTH-1:0]    wrAddr,
  output logic [ADDRWIDTH-1:0]    rdAddr,
  output logic                    preLoad,
  output logic                    load,
  output logic                    busy,
  output logic                    full,
  output logic                    empty,
  output logic [ADDRWIDTH:0]      occupancy,
  output logic                    l1Dropped,
  output logic [DROPCNTWIDTH-1:0] dropCount
);

  localparam logic [ADDRWIDTH:0]    DEPTH    = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [ADDRWIDTH:0]    PTR_ONE  = (ADDRWIDTH+1)'(1);
  localparam logic [DROPCNTWIDTH-1:0] CNT_ONE = DROPCNTWIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRELOAD = 2'd1,
    S_LOAD    = 2'd2,
    S_BUSY    = 2'd3
  } rd_state_e;

  rd_state_e                 state_q, state_d;
  logic [ADDRWIDTH:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDRWIDTH:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDRWIDTH-1:0]      wr_addr_q, wr_addr_d;
  logic [ADDRWIDTH-1:0]      rd_addr_q, rd_addr_d;
  logic                      wren_q, wren_d;
  logic                      dropped_q, dropped_d;
  logic [DROPCNTWIDTH-1:0]   drop_cnt_q, drop_cnt_d;
  logic                      full_q, full_d;
  logic                      empty_q, empty_d;
  logic                      reserve_full_q, reserve_full_d;
  logic [ADDRWIDTH:0]        occ_d;
  logic [ADDRWIDTH+1:0]      reserved_d;

  // Write path: an accepted L1A raises wren for one cycle; the pointer and
  // wrAddr are committed on the following edge so wrAddr trails wren by one.
  always_comb begin
    wren_d     = l1a & ~reserve_full_q;
    dropped_d  = l1a & reserve_full_q;
    wr_ptr_d   = wr_ptr_q;
    wr_addr_d  = wr_addr_q;
    drop_cnt_d = drop_cnt_q;
    if (wren_q) begin
      wr_addr_d = wr_ptr_q[ADDRWIDTH-1:0];
      wr_ptr_d  = wr_ptr_q + PTR_ONE;
    end
    if (dropped_d && (drop_cnt_q != {DROPCNTWIDTH{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_ONE;
    end
  end

  // Read sequencer; occupancy is released only when readout reports rdDone.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (rdReq && !empty_q) begin
          state_d = S_PRELOAD;
        end
      end
      S_PRELOAD: state_d = S_LOAD;
      S_LOAD:    state_d = S_BUSY;
      S_BUSY: begin
        if (rdDone) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rd_addr_d = rd_ptr_d[ADDRWIDTH-1:0];
  end

  // Acceptance also counts a write that is granted but not yet committed,
  // otherwise a back-to-back L1A could overfill the buffer by one event.
  always_comb begin
    occ_d          = wr_ptr_d - rd_ptr_d;
    full_d         = (occ_d == DEPTH);
    empty_d        = (occ_d == '0);
    reserved_d     = {1'b0, occ_d} + {{(ADDRWIDTH+1){1'b0}}, wren_d};
    reserve_full_d = (reserved_d >= {1'b0, DEPTH});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      wren_q         <= 1'b0;
      dropped_q      <= 1'b0;
      drop_cnt_q     <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      reserve_full_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_addr_q      <= wr_addr_d;
      rd_addr_q      <= rd_addr_d;
      wren_q         <= wren_d;
      dropped_q      <= dropped_d;
      drop_cnt_q     <= drop_cnt_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      reserve_full_q <= reserve_full_d;
    end
  end

  assign wren      = wren_q;
  assign wrAddr    = wr_addr_q;
  assign rdAddr    = rd_addr_q;
  assign preLoad   = (state_q == S_PRELOAD);
  assign load      = (state_q == S_LOAD);
  assign busy      = (state_q == S_BUSY);
  assign full      = full_q;
  assign empty     = empty_q;
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign l1Dropped = dropped_q;
  assign dropCount = drop_cnt_q;

endmodule

// File: tb/tb_l1_buffer_addr_ctrl.sv
// Bench for l1_buffer_addr_ctrl: directed vector table, corner-case sequences
// and random traffic checked against an event-counting reference model.
module tb_l1_buffer_addr_ctrl;

  localparam int AW    = 7;
  localparam int DW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int DMAX  = (1 << DW) - 1;

  logic          clk, reset, l1a, rdReq, rdDone;
  logic          wren, preLoad, load, busy, full, empty, l1Dropped;
  logic [AW-1:0] wrAddr, rdAddr;
  logic [AW:0]   occupancy;
  logic [DW-1:0] dropCount;

  int n_checks = 0;
  int n_errors = 0;

  l1_buffer_addr_ctrl #(.ADDRWIDTH(AW), .DROPCNTWIDTH(DW)) dut (
    .clk(clk), .reset(reset), .l1a(l1a), .rdReq(rdReq), .rdDone(rdDone),
    .wren(wren), .wrAddr(wrAddr), .rdAddr(rdAddr), .preLoad(preLoad),
    .load(load), .busy(busy), .full(full), .empty(empty),
    .occupancy(occupancy), .l1Dropped(l1Dropped), .dropCount(dropCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts of committed writes and completed reads, a
  // pending-grant flag, the read phase number and the drop tally.
  int m_written, m_read, m_pending, m_drop, m_drops, m_stage, m_last_wr;

  function automatic void model_reset();
    m_written = 0; m_read = 0; m_pending = 0; m_drop = 0;
    m_drops = 0; m_stage = 0; m_last_wr = 0;
  endfunction

  function automatic void model_edge(input bit a, input bit r, input bit d);
    int occ;
    bit take;
    occ  = m_written - m_read;
    take = a && ((occ + m_pending) < DEPTH);
    if (m_pending != 0) begin
      m_last_wr = m_written % DEPTH;
      m_written++;
    end
    case (m_stage)
      0: if (r && occ > 0) m_stage = 1;
      1: m_stage = 2;
      2: m_stage = 3;
      default: if (d) begin m_read++; m_stage = 0; end
    endcase
    m_drop = (a && !take) ? 1 : 0;
    if (m_drop != 0 && m_drops < DMAX) m_drops++;
    m_pending = take ? 1 : 0;
  endfunction

  task automatic check_model();
    int occ;
    occ = m_written - m_read;
    chk("wren", int'(wren), m_pending);
    chk("wrAddr", int'(wrAddr), m_last_wr);
    chk("rdAddr", int'(rdAddr), m_read % DEPTH);
    chk("preLoad", int'(preLoad), (m_stage == 1) ? 1 : 0);
    chk("load", int'(load), (m_stage == 2) ? 1 : 0);
    chk("busy", int'(busy), (m_stage == 3) ? 1 : 0);
    chk("full", int'(full), (occ == DEPTH) ? 1 : 0);
    chk("empty", int'(empty), (occ == 0) ? 1 : 0);
    chk("occupancy", int'(occupancy), occ);
    chk("l1Dropped", int'(l1Dropped), m_drop);
    chk("dropCount", int'(dropCount), m_drops);
  endtask

  task automatic step(input bit a, input bit r, input bit d);
    l1a = a; rdReq = r; rdDone = d;
    model_edge(a, r, d);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b0; l1a = 1'b0; rdReq = 1'b0; rdDone = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit l1a, rd_req, rd_done;
    int wren, wr_addr, occ, empty, pre, ld, bsy, rd_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input bit a, input bit r, input bit d, input int w,
                               input int wa, input int o, input int e, input int p,
                               input int l, input int b, input int ra);
    vec_t v;
    v.l1a = a; v.rd_req = r; v.rd_done = d; v.wren = w; v.wr_addr = wa;
    v.occ = o; v.empty = e; v.pre = p; v.ld = l; v.bsy = b; v.rd_addr = ra;
    return v;
  endfunction

  initial begin
    //                 l1a rq dn | wren wa occ emp pre ld bsy ra
    vecs.push_back(mkv(1, 0, 0,    1,   0, 0,  1,  0,  0, 0,  0));
    vecs.push_back(mkv(0, 0, 0,    0,   0, 1,  0,  0,  0, 0,  0));
    vecs.push_back(mkv(1, 0, 0,    1,   0, 1,  0,  0,  0, 0,  0));
    vecs.push_back(mkv(1, 0, 0,    1,   1, 2,  0,  0,  0, 0,  0));
    vecs.push_back(mkv(1, 0, 0,    1,   2, 3,  0,  0,  0, 0,  0));
    vecs.push_back(mkv(1, 0, 0,    1,   3, 4,  0,  0,  0, 0,  0));
    vecs.push_back(mkv(0, 0, 0,    0,   4, 5,  0,  0,  0, 0,  0));
    vecs.push_back(mkv(0, 1, 0,    0,   4, 5,  0,  1,  0, 0,  0));
    vecs.push_back(mkv(0, 0, 0,    0,   4, 5,  0,  0,  1, 0,  0));
    vecs.push_back(mkv(0, 0, 0,    0,   4, 5,  0,  0,  0, 1,  0));
    vecs.push_back(mkv(0, 0, 1,    0,   4, 4,  0,  0,  0, 0,  1));
    vecs.push_back(mkv(0, 0, 1,    0,   4, 4,  0,  0,  0, 0,  1));
    vecs.push_back(mkv(1, 1, 0,    1,   4, 4,  0,  1,  0, 0,  1));
    vecs.push_back(mkv(0, 0, 1,    0,   5, 5,  0,  0,  1, 0,  1));
    vecs.push_back(mkv(0, 0, 0,    0,   5, 5,  0,  0,  0, 1,  1));
    vecs.push_back(mkv(1, 0, 1,    1,   5, 4,  0,  0,  0, 0,  2));
    vecs.push_back(mkv(0, 0, 0,    0,   6, 5,  0,  0,  0, 0,  2));

    reset = 1'b0; l1a = 1'b0; rdReq = 1'b0; rdDone = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_wren", int'(wren), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_dropCount", int'(dropCount), 0);
    chk("rst_preLoad", int'(preLoad | load | busy), 0);
    reset = 1'b1;

    // Directed vector table from reset.
    for (int i = 0; i < vecs.size(); i++) begin
      l1a = vecs[i].l1a; rdReq = vecs[i].rd_req; rdDone = vecs[i].rd_done;
      @(negedge clk);
      chk("vec_wren", int'(wren), vecs[i].wren);
      chk("vec_wrAddr", int'(wrAddr), vecs[i].wr_addr);
      chk("vec_occupancy", int'(occupancy), vecs[i].occ);
      chk("vec_empty", int'(empty), vecs[i].empty);
      chk("vec_preLoad", int'(preLoad), vecs[i].pre);
      chk("vec_load", int'(load), vecs[i].ld);
      chk("vec_busy", int'(busy), vecs[i].bsy);
      chk("vec_rdAddr", int'(rdAddr), vecs[i].rd_addr);
      $display("vector %0d: l1a=%0b rdReq=%0b rdDone=%0b -> wren=%0b wrAddr=%0d occ=%0d rdAddr=%0d",
               i, vecs[i].l1a, vecs[i].rd_req, vecs[i].rd_done, wren, wrAddr, occupancy, rdAddr);
    end

    // Fill to full, drop the 129th, then drop an L1A coinciding with rdDone.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("full_drop_wren", int'(wren), 0);
    chk("full_drop_pulse", int'(l1Dropped), 1);
    chk("full_dropCount", int'(dropCount), 1);
    chk("full_wrAddr", int'(wrAddr), DEPTH - 1);
    chk("full_flag", int'(full), 1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("same_edge_dropCount", int'(dropCount), 2);
    chk("same_edge_occupancy", int'(occupancy), DEPTH - 1);
    step(1'b1, 1'b0, 1'b0);
    chk("after_free_wren", int'(wren), 1);
    step(1'b0, 1'b0, 1'b0);
    $display("sequence full/drop: dropCount=%0d occupancy=%0d", dropCount, occupancy);

    // Reset asserted while in LOAD.
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("load_before_reset", int'(load), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_load", int'(load), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_preLoad", int'(preLoad), 0);
    chk("async_occupancy", int'(occupancy), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (4) step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    $display("sequence reset-in-load: occupancy=%0d empty=%0b", occupancy, empty);

    // Write and read 130 events one at a time to exercise address wrap.
    do_reset();
    for (int e = 0; e < DEPTH + 2; e++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
    end
    chk("wrap_wrAddr", int'(wrAddr), (DEPTH + 1) % DEPTH);
    chk("wrap_rdAddr", int'(rdAddr), (DEPTH + 2) % DEPTH);
    chk("wrap_empty", int'(empty), 1);
    $display("sequence wrap: wrAddr=%0d rdAddr=%0d", wrAddr, rdAddr);

    // Random traffic in phases of differing trigger rate.
    do_reset();
    for (int ph = 0; ph < 8; ph++) begin
      int p_l1a;
      p_l1a = (ph % 3 == 0) ? 15 : ((ph % 3 == 1) ? 50 : 95);
      for (int c = 0; c < 500; c++) begin
        step(($urandom_range(99) < p_l1a), ($urandom_range(99) < 70),
             ($urandom_range(99) < 30));
      end
      $display("random phase %0d: l1a%%=%0d occupancy=%0d dropCount=%0d",
               ph, p_l1a, occupancy, dropCount);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
